add32_arbiter: RTL and testbench

ADD32_ARBITER -- requirements
Module: add32_arbiter

---
 rtl/add32_arbiter.sv | 145 ++++++++++++++
 tb/tb_add32_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/add32_arbiter.sv
// Two-requester round-robin arbiter in front of a 32-bit adder built from one
// 16-bit ripple adder used in two passes (low half, then high half with carry).

module ripple_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module add32_arbiter #(
  parameter int RR_START = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_id
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ptr;
  logic        grant_any;
  logic        grant_id;
  logic        accept;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        carry_q;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_s;
  logic        add_cin;
  logic        add_cout;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp_valid  = 1'b0;
    add_a      = a_q[15:0];
    add_b      = b_q[15:0];
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !Reset) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = LO;
        end
      end
      LO: state_nxt = HI;
      HI: begin
        add_a     = a_q[31:16];
        add_b     = b_q[31:16];
        add_cin   = carry_q;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  ripple_adder #(.W(16)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= (RR_START != 0);
      carry_q  <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr    <= ~grant_id;
        rsp_id <= grant_id;
      end
      if (state == LO) begin
        rsp_sum[15:0] <= add_s;
        carry_q       <= add_cout;
      end
      if (state == HI) begin
        rsp_sum[31:16] <= add_s;
        rsp_cout       <= add_cout;
      end
    end
  end

  // Operands are captured once at acceptance so later port changes cannot leak in.
  always_ff @(posedge Clk) begin
    if (accept) begin
      a_q <= grant_id ? req1_a : req0_a;
      b_q <= grant_id ? req1_b : req0_b;
    end
  end

endmodule

// File: tb/tb_add32_arbiter.sv
// Directed and randomized checks of add32_arbiter: latency, carry, arbitration,
// backpressure, reset mid-add, and a scoreboarded random run.

module tb_add32_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_id;

  int errs = 0;
  int checks = 0;

  add32_arbiter #(.RR_START(0)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Issue one add from an idle DUT and check the full response timeline.
  task automatic run_add(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp, input string tag);
    @(negedge Clk);
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    @(negedge Clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF; req0_b = 32'h5555_AAAA;
    req1_a = 32'hCAFE_F00D; req1_b = 32'h1234_4321;
    chk({tag, "_v1"}, rsp_valid, 0);
    @(negedge Clk);
    chk({tag, "_v2"}, rsp_valid, 0);
    @(negedge Clk);
    chk({tag, "_v3"}, rsp_valid, 1);
    chk({tag, "_sum"}, rsp_sum, exp[31:0]);
    chk({tag, "_cout"}, rsp_cout, exp[32]);
    chk({tag, "_id"}, rsp_id, id);
    @(negedge Clk);
    chk({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    int bad;
    int got_n;
    int cyc;
    int acc_cnt;
    logic [33:0] q[$];
    logic [33:0] e;
    logic [31:0] s_hold;
    logic        c_hold;
    logic        i_hold;
    bit          exp_ids[4];
    logic [32:0] exp_sums[4];

    // Reset state, sampled with Reset high and no accepted request.
    #3;
    req0_valid = 1'b1;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_id", rsp_id, 0);
    req0_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("idle_noreq0", req0_ready, 0);
    chk("idle_noreq1", req1_ready, 0);

    run_add(1'b0, 32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000, "single");
    run_add(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, "carry");
    run_add(1'b0, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, "msb");

    // Contention from a fresh reset: grants must alternate 0,1,0,1.
    do_reset();
    exp_ids  = '{0, 1, 0, 1};
    exp_sums = '{33'h0_0000_001E, 33'h1_0000_0001, 33'h0_0000_001E, 33'h1_0000_0001};
    @(negedge Clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10;         req0_b = 32'd20;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF;  req1_b = 32'h0000_0002;
    got_n = 0;
    for (int n = 0; n < 40 && got_n < 4; n++) begin
      @(negedge Clk);
      if (rsp_valid) begin
        chk("cont_id", rsp_id, exp_ids[got_n]);
        chk("cont_sum", {rsp_cout, rsp_sum}, exp_sums[got_n]);
        chk("cont_rdy", {req0_ready, req1_ready}, 0);
        got_n++;
      end
    end
    chk("cont_count", got_n, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    while (rsp_valid) @(negedge Clk);

    // Backpressure: hold rsp_ready low for 10 cycles in RESP.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_0100; req0_b = 32'h0000_0200;
    @(negedge Clk);
    req0_valid = 1'b0;
    for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge Clk);
    chk("bp_reach", rsp_valid, 1);
    s_hold = rsp_sum; c_hold = rsp_cout; i_hold = rsp_id;
    chk("bp_sum", {rsp_cout, rsp_sum}, 33'h0_0000_0300);
    req0_valid = 1'b1; req1_valid = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clk);
      if (!rsp_valid || rsp_sum !== s_hold || rsp_cout !== c_hold || rsp_id !== i_hold ||
          req0_ready || req1_ready) bad++;
    end
    chk("bp_stable", bad, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge Clk);
    chk("bp_once", rsp_valid, 0);
    @(negedge Clk);
    chk("bp_idle", rsp_valid, 0);

    // Reset while the 0x12345678 + 0x11111111 add is in HI.
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111;
    #1;
    chk("rsthi_acc", req0_ready, 1);
    @(negedge Clk);
    req0_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rsthi_valid", rsp_valid, 0);
    chk("rsthi_sum", rsp_sum, 0);
    @(negedge Clk);
    Reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge Clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("rsthi_none", bad, 0);
    run_add(1'b0, 32'd3, 32'd4, 33'd7, "after_rst");

    // Random traffic with scoreboard; operands re-randomized every cycle.
    cyc = 0;
    acc_cnt = 0;
    while ((acc_cnt < 10000 || q.size() > 0) && cyc < 70000) begin
      @(negedge Clk);
      cyc++;
      rsp_ready = ($urandom_range(3) != 0);
      if (acc_cnt < 10000) begin
        req0_valid = $urandom_range(1);
        req1_valid = $urandom_range(1);
        if (!req0_valid && !req1_valid) req1_valid = 1'b1;
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      #1;
      chk("rnd_excl", req0_ready & req1_ready, 0);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rnd_spurious", rsp_valid, 0);
        else begin
          e = q.pop_front();
          chk("rnd_sum", rsp_sum, e[31:0]);
          chk("rnd_cout", rsp_cout, e[32]);
          chk("rnd_id", rsp_id, e[33]);
        end
      end
      if (req0_valid && req0_ready) begin
        q.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}});
        acc_cnt++;
      end
      if (req1_valid && req1_ready) begin
        q.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}});
        acc_cnt++;
      end
    end
    chk("rnd_count", acc_cnt, 10000);
    chk("rnd_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
